// File: rtl/arvi_pkg.sv
// Shared types and constants for the instruction fetch front end.
package arvi_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding slot behind the decoder output register.
module fetch_skid_buf
  import arvi_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic            i_push,
  input  logic            i_pop,
  input  logic [31:0]     i_instr,
  input  logic [XLEN-1:0] i_pc,
  output logic            o_full,
  output logic [31:0]     o_instr,
  output logic [XLEN-1:0] o_pc
);

  logic            full_q, full_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;

  // Flush beats push; a simultaneous push and pop refills the slot.
  always_comb begin
    full_d  = full_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (i_flush) begin
      full_d = 1'b0;
    end else if (i_push) begin
      full_d  = 1'b1;
      instr_d = i_instr;
      pc_d    = i_pc;
    end else if (i_pop) begin
      full_d = 1'b0;
    end else begin
      full_d = full_q;
    end
  end

  // Buffer storage.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= {XLEN{1'b0}};
    end else begin
      full_q  <= full_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign o_full  = full_q;
  assign o_instr = instr_q;
  assign o_pc    = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch unit: owns the PC, issues word reads, and presents a stall-safe
// instruction/PC pair to the decoder, with redirect and misalignment handling.
module instr_fetch
  import arvi_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  output logic            o_IF_req,
  output logic [XLEN-1:0] o_IF_addr,
  input  logic            i_IF_ack,
  input  logic [31:0]     i_IF_data,
  output logic [31:0]     o_Instr,
  output logic [XLEN-1:0] o_PC,
  output logic            o_valid,
  input  logic            i_Stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic            o_Ex_misaligned
);

  fetch_state_t    state_q, state_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic            valid_q, valid_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  logic            tgt_halt_q, tgt_halt_d;
  logic            mis_q, mis_d;

  logic            ack_s, fetched_s, slot_free_s, misaligned_s, outstanding_s;
  logic            buf_full_s, buf_push_s, buf_pop_s, buf_flush_s;
  logic [31:0]     buf_instr_s;
  logic [XLEN-1:0] buf_pc_s;
  logic [1:0]      occ_s;

  assign ack_s         = req_q & i_IF_ack;
  assign fetched_s     = ack_s & ~kill_q;
  assign slot_free_s   = ~valid_q | ~i_Stall;
  assign misaligned_s  = (i_redirect_pc[1:0] != 2'b00);
  assign outstanding_s = req_q & ~i_IF_ack;

  fetch_skid_buf #(.XLEN(XLEN)) u_skid (
    .i_clk   (i_clk),
    .i_rstn  (i_rstn),
    .i_flush (buf_flush_s),
    .i_push  (buf_push_s),
    .i_pop   (buf_pop_s),
    .i_instr (i_IF_data),
    .i_pc    (addr_q),
    .o_full  (buf_full_s),
    .o_instr (buf_instr_s),
    .o_pc    (buf_pc_s)
  );

  // Next-state, bus and output-slot control.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    kill_d      = kill_q;
    tgt_d       = tgt_q;
    tgt_halt_d  = tgt_halt_q;
    mis_d       = 1'b0;
    buf_push_s  = 1'b0;
    buf_pop_s   = 1'b0;
    buf_flush_s = 1'b0;
    occ_s       = 2'd0;

    if (i_redirect) begin
      buf_flush_s = 1'b1;
      valid_d     = 1'b0;
      mis_d       = misaligned_s;
      // An unacked request must stay on the bus; its data is dropped later.
      if (outstanding_s) begin
        state_d    = DRAIN;
        kill_d     = 1'b1;
        tgt_d      = i_redirect_pc;
        tgt_halt_d = misaligned_s;
      end else if (misaligned_s) begin
        state_d = HALT;
        kill_d  = 1'b0;
        req_d   = 1'b0;
      end else begin
        state_d = FETCH;
        kill_d  = 1'b0;
        req_d   = 1'b1;
        addr_d  = i_redirect_pc;
      end
    end else begin
      case (state_q)
        FETCH, FULL: begin
          buf_pop_s  = slot_free_s & buf_full_s;
          buf_push_s = fetched_s & (~slot_free_s | buf_full_s);
          if (slot_free_s) begin
            valid_d = buf_full_s | fetched_s;
            if (buf_full_s) begin
              instr_d = buf_instr_s;
              pc_d    = buf_pc_s;
            end else if (fetched_s) begin
              instr_d = i_IF_data;
              pc_d    = addr_q;
            end else begin
              instr_d = instr_q;
              pc_d    = pc_q;
            end
          end else begin
            valid_d = valid_q;
          end
          // Request only if output+buffer still has room after this cycle.
          occ_s   = {1'b0, valid_d} + {1'b0, buf_push_s | (buf_full_s & ~buf_pop_s)};
          req_d   = outstanding_s | (occ_s != 2'd2);
          addr_d  = ack_s ? (addr_q + XLEN'(PC_STEP)) : addr_q;
          state_d = req_d ? FETCH : FULL;
        end
        DRAIN: begin
          if (ack_s) begin
            kill_d = 1'b0;
            if (tgt_halt_q) begin
              state_d = HALT;
              req_d   = 1'b0;
            end else begin
              state_d = FETCH;
              req_d   = 1'b1;
              addr_d  = tgt_q;
            end
          end else begin
            state_d = DRAIN;
          end
        end
        HALT: begin
          state_d = HALT;
          req_d   = 1'b0;
        end
        default: begin
          state_d = FETCH;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= FETCH;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      tgt_q      <= RESET_PC;
      tgt_halt_q <= 1'b0;
      mis_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      kill_q     <= kill_d;
      tgt_q      <= tgt_d;
      tgt_halt_q <= tgt_halt_d;
      mis_q      <= mis_d;
    end
  end

  assign o_IF_req        = req_q;
  assign o_IF_addr       = addr_q;
  assign o_valid         = valid_q;
  assign o_Instr         = instr_q;
  assign o_PC            = pc_q;
  assign o_Ex_misaligned = mis_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked
// against an instruction-stream scoreboard (sequential PCs, restart on redirect).
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        o_IF_req;
  logic [31:0] o_IF_addr;
  logic        i_IF_ack = 1'b0;
  logic [31:0] i_IF_data = 32'd0;
  logic [31:0] o_Instr;
  logic [31:0] o_PC;
  logic        o_valid;
  logic        i_Stall = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'd0;
  logic        o_Ex_misaligned;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] exp_pc = RESET_PC;
  bit          halted = 1'b0;
  int          gap = 0;
  int          max_gap = 0;
  logic [31:0] s1_words [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113};

  always #5 i_clk = ~i_clk;

  instr_fetch #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .o_IF_req        (o_IF_req),
    .o_IF_addr       (o_IF_addr),
    .i_IF_ack        (i_IF_ack),
    .i_IF_data       (i_IF_data),
    .o_Instr         (o_Instr),
    .o_PC            (o_PC),
    .o_valid         (o_valid),
    .i_Stall         (i_Stall),
    .i_redirect      (i_redirect),
    .i_redirect_pc   (i_redirect_pc),
    .o_Ex_misaligned (o_Ex_misaligned)
  );

  // Instruction memory contents: the three plan words at reset PC, else address-derived.
  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == RESET_PC)              return 32'h0000_0013;
    else if (a == RESET_PC + 32'd4) return 32'h0010_0093;
    else if (a == RESET_PC + 32'd8) return 32'h0020_0113;
    else                            return {a[31:2] ^ 30'h2BAD_C0DE, 2'b11};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs from the current outputs, score, advance, check.
  task automatic tick(input bit ack_en, input bit stall, input bit redir, input logic [31:0] tgt);
    logic        pre_req, pre_ack, pre_valid;
    logic [31:0] pre_addr, pre_instr, pre_pc;
    i_IF_ack      = ack_en & o_IF_req;
    i_IF_data     = mem(o_IF_addr);
    i_Stall       = stall;
    i_redirect    = redir;
    i_redirect_pc = tgt;
    pre_req   = o_IF_req;
    pre_ack   = i_IF_ack;
    pre_valid = o_valid;
    pre_addr  = o_IF_addr;
    pre_instr = o_Instr;
    pre_pc    = o_PC;
    if (o_valid && !stall) begin
      chk("stream_pc", o_PC, exp_pc);
      chk("stream_instr", o_Instr, mem(exp_pc));
      exp_pc = exp_pc + 32'd4;
      gap = 0;
    end else begin
      gap++;
    end
    if (redir) begin
      exp_pc = tgt;
      halted = (tgt[1:0] != 2'b00);
      gap = 0;
    end
    if (halted) gap = 0;
    if (gap > max_gap) max_gap = gap;
    @(posedge i_clk); #1;
    chk("addr_align", {30'd0, o_IF_addr[1:0]}, 32'd0);
    chk("misaligned_pulse", {31'd0, o_Ex_misaligned}, {31'd0, (redir && tgt[1:0] != 2'b00)});
    if (pre_req && !pre_ack) begin
      chk("bus_hold_req", {31'd0, o_IF_req}, 32'd1);
      chk("bus_hold_addr", o_IF_addr, pre_addr);
    end
    if (redir || halted) begin
      chk("flush_valid", {31'd0, o_valid}, 32'd0);
    end else if (pre_valid && stall) begin
      chk("stall_hold_valid", {31'd0, o_valid}, 32'd1);
      chk("stall_hold_pc", o_PC, pre_pc);
      chk("stall_hold_instr", o_Instr, pre_instr);
    end
  endtask

  initial begin
    // Reset values.
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_req", {31'd0, o_IF_req}, 32'd0);
    chk("rst_addr", o_IF_addr, RESET_PC);
    chk("rst_instr", o_Instr, NOP);
    chk("rst_pc", o_PC, RESET_PC);
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_mis", {31'd0, o_Ex_misaligned}, 32'd0);
    @(negedge i_clk);
    i_rstn = 1'b1;

    // Zero-wait streaming from reset.
    tick(1'b0, 1'b0, 1'b0, 32'd0);
    chk("first_req", {31'd0, o_IF_req}, 32'd1);
    chk("first_addr", o_IF_addr, RESET_PC);
    chk("first_valid", {31'd0, o_valid}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'd0);
      chk("s1_valid", {31'd0, o_valid}, 32'd1);
      chk("s1_pc", o_PC, RESET_PC + 32'(4 * k));
      chk("s1_instr", o_Instr, s1_words[k]);
      chk("s1_addr", o_IF_addr, RESET_PC + 32'(4 * (k + 1)));
    end

    // Decoder stall: one word buffered, then request drops.
    for (int k = 0; k < 5; k++) begin
      tick(1'b1, 1'b1, 1'b0, 32'd0);
      chk("stall_req_low", {31'd0, o_IF_req}, 32'd0);
      chk("stall_pc", o_PC, RESET_PC + 32'd8);
    end
    tick(1'b0, 1'b0, 1'b0, 32'd0);
    chk("unstall_pc", o_PC, RESET_PC + 32'd12);
    chk("unstall_req", {31'd0, o_IF_req}, 32'd1);
    tick(1'b0, 1'b0, 1'b0, 32'd0);
    chk("pending_valid", {31'd0, o_valid}, 32'd0);
    chk("pending_addr", o_IF_addr, RESET_PC + 32'h10);

    // Redirect with a request outstanding.
    tick(1'b0, 1'b0, 1'b1, 32'h8000_0100);
    chk("drain_addr", o_IF_addr, RESET_PC + 32'h10);
    tick(1'b0, 1'b0, 1'b0, 32'd0);
    chk("drain_req", {31'd0, o_IF_req}, 32'd1);
    chk("drain_addr2", o_IF_addr, RESET_PC + 32'h10);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    chk("drain_discard", {31'd0, o_valid}, 32'd0);
    chk("drain_target", o_IF_addr, 32'h8000_0100);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    chk("drain_first_pc", o_PC, 32'h8000_0100);

    // Redirect coinciding with an ack.
    tick(1'b1, 1'b0, 1'b1, 32'h8000_0200);
    chk("same_cyc_addr", o_IF_addr, 32'h8000_0200);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    chk("same_cyc_pc", o_PC, 32'h8000_0200);
    chk("same_cyc_valid", {31'd0, o_valid}, 32'd1);

    // Misaligned redirect halts until an aligned one.
    tick(1'b1, 1'b0, 1'b1, 32'h8000_0102);
    chk("mis_req", {31'd0, o_IF_req}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick(1'b1, 1'b0, 1'b0, 32'd0);
      chk("halt_req", {31'd0, o_IF_req}, 32'd0);
    end
    tick(1'b1, 1'b0, 1'b1, 32'h8000_0300);
    chk("resume_req", {31'd0, o_IF_req}, 32'd1);
    chk("resume_addr", o_IF_addr, 32'h8000_0300);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    chk("resume_pc", o_PC, 32'h8000_0300);

    // Asynchronous reset with output and buffer full, ack held high.
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    tick(1'b1, 1'b1, 1'b0, 32'd0);
    chk("full_req", {31'd0, o_IF_req}, 32'd0);
    #2;
    i_IF_ack = 1'b1;
    i_rstn   = 1'b0;
    #1;
    chk("arst_req", {31'd0, o_IF_req}, 32'd0);
    chk("arst_addr", o_IF_addr, RESET_PC);
    chk("arst_instr", o_Instr, NOP);
    chk("arst_pc", o_PC, RESET_PC);
    chk("arst_valid", {31'd0, o_valid}, 32'd0);
    @(posedge i_clk); #1;
    chk("arst_hold_valid", {31'd0, o_valid}, 32'd0);
    exp_pc = RESET_PC;
    halted = 1'b0;
    gap    = 0;
    @(negedge i_clk);
    i_rstn   = 1'b1;
    i_IF_ack = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 32'd0);
    chk("rerun_addr", o_IF_addr, RESET_PC);
    chk("rerun_req", {31'd0, o_IF_req}, 32'd1);
    tick(1'b1, 1'b0, 1'b0, 32'd0);
    chk("rerun_pc", o_PC, RESET_PC);

    // Random traffic: wait states, stalls, redirects (some misaligned, some near wrap).
    for (int c = 0; c < 3000; c++) begin
      bit          r;
      logic [31:0] t;
      r = ($urandom_range(0, 99) < 3);
      t = {16'h8000, 16'($urandom)} & 32'hFFFF_FFFC;
      if ($urandom_range(0, 9) == 0) t = 32'hFFFF_FFF0;
      if ($urandom_range(0, 4) == 0) t = t | 32'($urandom_range(1, 3));
      tick($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 3, r, t);
    end
    chk("liveness_gap", {31'd0, (max_gap <= 60)}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Front-end fetch unit that drives the instruction word into the main control decoder.
- Owns the PC and issues word reads on the instruction-memory request/ack bus.
- Buffers fetched words so the decoder-side stall never loses an instruction.
- Applies PC redirects from branch/jump/trap logic, discarding in-flight fetches.

Parameters:
- RESET_PC, 32'h8000_0000, PC fetched first after reset release.
- XLEN, 32, PC/address and instruction width.

Ports:
- i_clk  in  1  core clock.
- i_rstn  in  1  asynchronous active-low reset.
- o_IF_req  out  1  memory read request.
- o_IF_addr  out  XLEN  word address of request; bits[1:0] always 0.
- i_IF_ack  in  1  request accepted and data valid, same cycle.
- i_IF_data  in  32  instruction word, valid when i_IF_ack.
- o_Instr  out  32  instruction to decoder.
- o_PC  out  XLEN  PC of o_Instr.
- o_valid  out  1  o_Instr/o_PC valid.
- i_Stall  in  1  decoder not consuming; output must hold.
- i_redirect  in  1  one-cycle pulse, load new PC.
- i_redirect_pc  in  XLEN  target PC.
- o_Ex_misaligned  out  1  one-cycle pulse, redirect target not word aligned.

Behaviour:
- One clock domain (i_clk); reset is asynchronous and active-low (i_rstn).
- Reset values: o_IF_req=0, o_IF_addr=RESET_PC, o_Instr=32'h0000_0013 (NOP), o_PC=RESET_PC, o_valid=0, o_Ex_misaligned=0, buffer empty, state FETCH, kill=0.
- First cycle after i_rstn rises: o_IF_req=1, o_IF_addr=RESET_PC.
- Bus rule: once o_IF_req is high, it and o_IF_addr stay stable until i_IF_ack.
- Ack at cycle n (not killed): the word appears on o_Instr/o_PC with o_valid=1 at cycle n+1 if the output slot is free or being consumed; otherwise it goes to the 1-entry buffer.
- Fetch PC advances by 4 per ack, with wrap modulo 2^XLEN.
- Throughput is one instruction per cycle when ack is zero-wait.
- Consumption: the output is consumed in a cycle with o_valid=1 and i_Stall=0. On consumption the buffer entry, if any, moves to the output next cycle.
- Flow control: o_IF_req is asserted only if, after this cycle's consumption, output+buffer can hold one more word. With the output and buffer full, req drops (state FULL) and no words are lost.
- States:
  - FETCH: issuing requests.
  - FULL: storage full, req low; returns to FETCH when a slot frees.
  - DRAIN: outstanding request being killed.
  - HALT: misaligned target, no fetch.
- Redirect (priority over stall and ack):
  - Next cycle: o_valid=0 and the buffer is flushed.
  - No request outstanding: o_IF_addr=i_redirect_pc, req=1 next cycle.
  - Request outstanding and unacked: keep it (bus rule), set kill, enter DRAIN. Discard the data at ack, then issue the target next cycle.
  - Ack in the same cycle as redirect: that data is discarded and no DRAIN is needed.
- Redirect with i_redirect_pc[1:0]!=0:
  - o_Ex_misaligned=1 for one cycle.
  - Enter HALT, o_valid=0, req low after any outstanding drain.
  - Leave HALT only on an aligned redirect.
- Redirect while in DRAIN: the latest target replaces the pending one.
- Reset mid-transaction: all state clears immediately; the in-flight ack is ignored.

Decomposition:
- Shared package arvi_pkg:
  - fetch_state_t enum {FETCH, FULL, DRAIN, HALT}.
  - NOP_INSTR = 32'h0000_0013.
  - PC_STEP = 4.
- One natural sub-module, fetch_skid_buf: 1-entry {instr, pc} buffer with full flag, flush input and push/pop.

Test Plan:
- Release reset, zero-wait ack returning 0x00000013, 0x00100093, 0x00200113 -> o_IF_addr 0x80000000/04/08 on consecutive cycles; o_valid from cycle 2 with matching o_PC, one instruction per cycle.
- Hold i_Stall=1 for 5 cycles during streaming -> o_Instr/o_PC constant. After one extra word is buffered, o_IF_req=0. On release, the words appear in order with no loss or duplication.
- Request at 0x80000010 pending with no ack, then i_redirect to 0x80000100 -> req/addr stay at 0x80000010 until ack. That data is never shown (o_valid=0); the next request goes to 0x80000100.
- i_redirect and i_IF_ack in the same cycle, target 0x80000200 -> acked word discarded; next o_IF_addr=0x80000200; first valid o_PC=0x80000200.
- i_redirect_pc=0x80000102 -> o_Ex_misaligned pulses exactly one cycle, o_IF_req stays 0. A later redirect to 0x80000300 resumes fetch there.
- Assert i_rstn=0 while a request is pending and the buffer is full -> outputs go to reset values asynchronously. After release, fetch restarts at RESET_PC.
